// File: rtl/code_lock_param_if.sv
// Digit strobe / status bundle for code_lock_param.
// CW must equal $clog2(CODE_LEN+1) of the attached lock.
interface code_lock_param_if #(
  parameter int CW = 3
) ();
  logic          b0;
  logic          b1;
  logic          prog_en;
  logic          unlock;
  logic          locked_out;
  logic [3:0]    fail_count;
  logic [CW-1:0] digit_count;

  modport master (
    output b0, b1, prog_en,
    input  unlock, locked_out,
    input  fail_count, digit_count
  );

  modport slave (
    input  b0, b1, prog_en,
    output unlock, locked_out,
    output fail_count, digit_count
  );
endinterface

// File: rtl/code_lock_param.sv
// Attempt-based code lock with fail counting and timed lockout.
// Define CODE_LOCK_PROG_EN to build the re-programmable code register.
module code_lock_param #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 100,
  parameter int                  LOCKOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  code_lock_param_if.slave bus
);

  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int UW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int TW = (UW > LW) ? UW : LW;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    PROGRAM  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                unlock_q;
  logic                unlock_d;
  logic                lock_q;
  logic                lock_d;
  logic [CODE_LEN-1:0] entry_q;
  logic [CODE_LEN-1:0] entry_full;
  logic [CODE_LEN:0]   entry_sh;
  logic [DW-1:0]       cnt_q;
  logic [3:0]          fails_q;
  logic [3:0]          fails_inc;
  logic [TW-1:0]       timer_q;
  logic [CODE_LEN-1:0] code_q;
  logic                digit_v;
  logic                last;
  logic                match;
  logic                fail_hit;
  logic                tmr_zero;
  logic                prog_ok;

  assign digit_v    = bus.b0 ^ bus.b1;
  assign entry_sh   = {entry_q, bus.b1};
  assign entry_full = entry_sh[CODE_LEN-1:0];
  assign last       = (cnt_q == DW'(CODE_LEN - 1));
  assign match      = (entry_full == code_q);
  assign tmr_zero   = (timer_q == '0);
  assign fails_inc  = (fails_q >= 4'(MAX_FAILS)) ? fails_q
                                                 : fails_q + 4'd1;
  assign fail_hit   = (fails_inc == 4'(MAX_FAILS));

`ifdef CODE_LOCK_PROG_EN
  logic code_we;

  assign prog_ok = bus.prog_en;
  // A 1-digit code completes on the very digit that leaves UNLOCKED.
  assign code_we = digit_v && last &&
                   ((state_q == PROGRAM) ||
                    (state_q == UNLOCKED && !tmr_zero && prog_ok));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= DEFAULT_CODE;
    end else if (code_we) begin
      code_q <= entry_full;
    end
  end
`else
  logic unused_prog;

  assign prog_ok     = 1'b0;
  assign unused_prog = bus.prog_en;
  assign code_q      = DEFAULT_CODE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      unlock_q <= unlock_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (digit_v && last) begin
          if (match) begin
            state_d = UNLOCKED;
          end else if (fail_hit) begin
            state_d = LOCKOUT;
          end
        end
      end
      UNLOCKED: begin
        if (tmr_zero) begin
          state_d = COLLECT;
        end else if (digit_v && prog_ok) begin
          state_d = last ? COLLECT : PROGRAM;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = COLLECT;
        end
      end
      PROGRAM: begin
        if (digit_v && last) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    unlock_d = 1'b0;
    lock_d   = 1'b0;
    unique case (1'b1)
      (state_d == UNLOCKED): unlock_d = 1'b1;
      (state_d == LOCKOUT):  lock_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      cnt_q   <= '0;
      fails_q <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (digit_v) begin
            if (last) begin
              entry_q <= '0;
              cnt_q   <= '0;
              if (match) begin
                fails_q <= '0;
                timer_q <= TW'(UNLOCK_CYCLES - 1);
              end else begin
                fails_q <= fails_inc;
                timer_q <= TW'(LOCKOUT_CYCLES - 1);
              end
            end else begin
              entry_q <= entry_full;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (!tmr_zero) begin
            timer_q <= timer_q - 1'b1;
            if (digit_v && prog_ok) begin
              if (last) begin
                fails_q <= '0;
              end else begin
                entry_q <= entry_full;
                cnt_q   <= cnt_q + 1'b1;
              end
            end
          end
        end
        LOCKOUT: begin
          if (tmr_zero) begin
            fails_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        PROGRAM: begin
          if (digit_v) begin
            if (last) begin
              entry_q <= '0;
              cnt_q   <= '0;
              fails_q <= '0;
            end else begin
              entry_q <= entry_full;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.unlock      = unlock_q;
  assign bus.locked_out  = lock_q;
  assign bus.fail_count  = fails_q;
  assign bus.digit_count = cnt_q;

endmodule

// File: tb/tb_code_lock_param.sv
// Scoreboard bench for code_lock_param at default parameters.
// Covers both builds; the programming scenario follows CODE_LOCK_PROG_EN.
module tb_code_lock_param;

  typedef struct {
    logic       unl;
    logic       lck;
    logic [3:0] fails;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];
  logic [4:0] m_code;
  int   m_fails;

  code_lock_param_if #(.CW(3)) bus ();

  code_lock_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic d);
    bus.b0 = ~d;
    bus.b1 = d;
    @(negedge clk);
    bus.b0 = 1'b0;
    bus.b1 = 1'b0;
  endtask

  task automatic attempt(input logic [4:0] code, input string nm);
    exp_t e;
    if (code == m_code) begin
      m_fails = 0;
      e.unl = 1'b1;
      e.lck = 1'b0;
    end else begin
      m_fails++;
      e.unl = 1'b0;
      e.lck = (m_fails == 3);
    end
    e.fails = 4'(m_fails);
    sb.push_back(e);
    for (int i = 4; i >= 0; i--) begin
      press(code[i]);
      n_checks++;
      if (bus.digit_count !== 3'((i == 0) ? 0 : 5 - i))
        $display("FAIL %s dcount[%0d] got %0d want %0d", nm, i,
                 bus.digit_count, (i == 0) ? 0 : 5 - i);
      else n_pass++;
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.unlock !== e.unl)
      $display("FAIL %s unlock got %b want %b", nm, bus.unlock, e.unl);
    else n_pass++;
    n_checks++;
    if (bus.locked_out !== e.lck)
      $display("FAIL %s locked_out got %b want %b", nm,
               bus.locked_out, e.lck);
    else n_pass++;
    n_checks++;
    if (bus.fail_count !== e.fails)
      $display("FAIL %s fail_count got %0d want %0d", nm,
               bus.fail_count, e.fails);
    else n_pass++;
  endtask

  task automatic wait_unlock(input int c0, input bit edge_digit);
    int c;
    c = c0;
    while (bus.unlock === 1'b1 && c < 2000) begin
      c++;
      if (edge_digit && c == 100) bus.b1 = 1'b1;
      @(negedge clk);
      bus.b1 = 1'b0;
    end
    n_checks++;
    if (c !== 100)
      $display("FAIL unlock_len got %0d want 100", c);
    else n_pass++;
    n_checks++;
    if (bus.digit_count !== 3'd0)
      $display("FAIL post_unlock_dcount got %0d want 0",
               bus.digit_count);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.unlock, bus.locked_out} !== 2'b00)
      $display("FAIL reset_out got %b want 00",
               {bus.unlock, bus.locked_out});
    else n_pass++;
    n_checks++;
    if ({bus.fail_count, bus.digit_count} !== 7'd0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0",
               bus.fail_count, bus.digit_count);
    else n_pass++;
    reset = 1'b0;
    m_code = 5'b01011;
    m_fails = 0;
  endtask

  task automatic test_unlock;
    attempt(5'b01011, "unlock");
    wait_unlock(0, 1'b1);
  endtask

  task automatic test_lockout;
    int c;
    attempt(5'b01010, "fail1");
    attempt(5'b01010, "fail2");
    attempt(5'b01010, "fail3");
    c = 0;
    for (int i = 4; i >= 0; i--) begin
      press(m_code[i]);
      c++;
    end
    n_checks++;
    if ({bus.unlock, bus.digit_count} !== 4'd0)
      $display("FAIL lock_ignore got u=%b d=%0d want 0/0",
               bus.unlock, bus.digit_count);
    else n_pass++;
    while (bus.locked_out === 1'b1 && c < 3000) begin
      c++;
      @(negedge clk);
    end
    n_checks++;
    if (c !== 1000)
      $display("FAIL lock_len got %0d want 1000", c);
    else n_pass++;
    n_checks++;
    if (bus.fail_count !== 4'd0)
      $display("FAIL lock_clear got %0d want 0", bus.fail_count);
    else n_pass++;
    m_fails = 0;
    attempt(5'b01011, "post_lock");
    wait_unlock(0, 1'b0);
  endtask

  task automatic test_both_pressed;
    exp_t e;
    e.unl = 1'b1;
    e.lck = 1'b0;
    e.fails = 4'd0;
    sb.push_back(e);
    press(1'b0);
    press(1'b1);
    bus.b0 = 1'b1;
    bus.b1 = 1'b1;
    repeat (2) @(negedge clk);
    bus.b0 = 1'b0;
    bus.b1 = 1'b0;
    n_checks++;
    if (bus.digit_count !== 3'd2)
      $display("FAIL both_dcount got %0d want 2", bus.digit_count);
    else n_pass++;
    press(1'b0);
    press(1'b1);
    n_checks++;
    if (bus.digit_count !== 3'd4)
      $display("FAIL both_dcount4 got %0d want 4", bus.digit_count);
    else n_pass++;
    press(1'b1);
    e = sb.pop_front();
    n_checks++;
    if (bus.unlock !== e.unl)
      $display("FAIL both_unlock got %b want %b", bus.unlock, e.unl);
    else n_pass++;
    wait_unlock(0, 1'b0);
  endtask

`ifdef CODE_LOCK_PROG_EN
  task automatic test_program;
    logic [4:0] nc;
    nc = 5'b11001;
    attempt(m_code, "prog_open");
    bus.prog_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      press(nc[i]);
      n_checks++;
      if (bus.unlock !== 1'b0 ||
          bus.digit_count !== 3'((i == 0) ? 0 : 5 - i))
        $display("FAIL prog[%0d] got u=%b d=%0d want 0/%0d", i,
                 bus.unlock, bus.digit_count, (i == 0) ? 0 : 5 - i);
      else n_pass++;
    end
    bus.prog_en = 1'b0;
    m_code = nc;
    attempt(5'b01011, "old_code");
    attempt(nc, "new_code");
    wait_unlock(0, 1'b0);
  endtask
`else
  task automatic test_prog_ignored;
    logic [4:0] nc;
    nc = 5'b11001;
    attempt(m_code, "noprog_open");
    bus.prog_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      press(nc[i]);
      n_checks++;
      if (bus.unlock !== 1'b1 || bus.digit_count !== 3'd0)
        $display("FAIL noprog[%0d] got u=%b d=%0d want 1/0", i,
                 bus.unlock, bus.digit_count);
      else n_pass++;
    end
    bus.prog_en = 1'b0;
    wait_unlock(5, 1'b0);
    attempt(5'b01011, "noprog_again");
    wait_unlock(0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid;
    press(1'b0);
    press(1'b1);
    press(1'b0);
    n_checks++;
    if (bus.digit_count !== 3'd3)
      $display("FAIL mid_dcount got %0d want 3", bus.digit_count);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.digit_count !== 3'd0)
      $display("FAIL async_reset got %0d want 0", bus.digit_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    m_code = 5'b01011;
    m_fails = 0;
    attempt(5'b01011, "after_reset");
    wait_unlock(0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    bus.b0 = 1'b0;
    bus.b1 = 1'b0;
    bus.prog_en = 1'b0;
    m_code = 5'b01011;
    m_fails = 0;
    test_reset();
    test_unlock();
    test_lockout();
    test_both_pressed();
`ifdef CODE_LOCK_PROG_EN
    test_program();
`else
    test_prog_ignored();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
